uart_msg_bridge: RTL and testbench
==================================

UART_MSG_BRIDGE -- requirements
Module: uart_msg_bridge

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set sys_clk_pin cycles per UART bit (legal range 8..65535).
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the word depth of each of the RX and TX FIFOs (power of 2, range 2..16).
REQ-003 sys_clk_pin  in  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-004 sys_rst_pin  in  1  reset, asynchronous, active-high.
REQ-005 uart_sin  in  1  serial data from host, asynchronous to sys_clk_pin.
REQ-006 uart_sout  out  1  serial data to host.
REQ-007 uart_ctsN  in  1  host clear-to-send, active-low, asynchronous.
REQ-008 uart_rtsN  out  1  request-to-send to host, active-low.
REQ-009 ppcMessageInput_put_pin  in  32  word to transmit to host.
REQ-010 EN_ppcMessageInput_put_pin  in  1  put strobe.
REQ-011 RDY_ppcMessageInput_put_pin  out  1  put accepted this cycle if EN is high.
REQ-012 ppcMessageOutput_get_pin  out  32  word received from host.
REQ-013 EN_ppcMessageOutput_get_pin  in  1  get strobe.
REQ-014 RDY_ppcMessageOutput_get_pin  out  1  get data valid.
REQ-015 framing_err  out  1  sticky flag: a received stop bit was 0.
REQ-016 overflow_err  out  1  sticky flag: a received word was dropped because the RX FIFO was full.

Function
REQ-017 The serial format SHALL be 8N1, LSB first, idle high.
REQ-018 Word byte order SHALL be little-endian on both paths: bits 7:0 first, then 15:8, 23:16, 31:24.
REQ-019 uart_sin and uart_ctsN SHALL pass through two-flop synchronizers before use.
REQ-020 RX FSM states SHALL be IDLE, START, DATA, STOP:
- IDLE→START on a synchronized falling edge.
- START: re-samples at CLKS_PER_BIT/2; returns to IDLE if the line is high (glitch), otherwise goes to DATA.
- DATA: samples 8 bits, each CLKS_PER_BIT apart at mid-bit.
- STOP: samples the stop bit at mid-bit, then returns to IDLE on the next cycle.
REQ-021 A stop bit sampled 0 SHALL discard that byte, keep the byte packer index unchanged, and set framing_err.
REQ-022 A valid byte SHALL load the packer at its index (0..3); the index SHALL wrap from 3 to 0.
REQ-023 On the 4th valid byte, the assembled word SHALL be pushed into the RX FIFO, and RDY_ppcMessageOutput_get_pin SHALL rise on the cycle after the stop-bit sample.
REQ-024 If the RX FIFO is full when a word completes, the word SHALL be dropped, FIFO contents SHALL be unchanged, and overflow_err SHALL be set.
REQ-025 uart_rtsN SHALL be 1 while RX FIFO occupancy is at least FIFO_DEPTH-1, and 0 otherwise.
REQ-026 RDY_ppcMessageOutput_get_pin SHALL equal RX-FIFO-not-empty.
REQ-027 ppcMessageOutput_get_pin SHALL present the FIFO head whenever RDY is high, and 0 when the FIFO is empty.
REQ-028 EN_ppcMessageOutput_get_pin high with RDY high SHALL pop one word; EN while RDY is low SHALL be ignored.
REQ-029 RDY_ppcMessageInput_put_pin SHALL equal TX-FIFO-not-full; EN high with RDY high SHALL push one word; EN while RDY is low SHALL be ignored.
REQ-030 A push and a pop on the same FIFO in the same cycle SHALL both succeed, including when the FIFO is full or empty-with-push-only-valid (occupancy unchanged).
REQ-031 TX FSM states SHALL be IDLE, START, DATA, STOP:
- A byte SHALL start only when the TX FIFO is non-empty (or a word is in progress) and synchronized ctsN is 0.
- ctsN is checked only at byte boundaries; a byte in flight SHALL complete regardless of ctsN.
REQ-032 The TX word SHALL be popped from the FIFO when its byte 0 starts; bytes 1..3 SHALL come from a holding register.
REQ-033 With ctsN low and TX idle, the start bit SHALL appear on uart_sout no later than 2 cycles after an accepted put.
REQ-034 Each bit SHALL be driven for exactly CLKS_PER_BIT cycles; the stop bit SHALL be one full bit; back-to-back bytes SHALL have no extra idle time.
REQ-035 The RX and TX paths SHALL operate fully independently and concurrently.

Reset
REQ-036 While sys_rst_pin is high, and on the first cycle after deassertion, outputs SHALL be:
- uart_sout=1, uart_rtsN=0
- RDY_ppcMessageInput_put_pin=1, RDY_ppcMessageOutput_get_pin=0, ppcMessageOutput_get_pin=0
- framing_err=0, overflow_err=0
REQ-037 Reset SHALL empty both FIFOs, clear the packer index and holding register, and return both FSMs to IDLE.
REQ-038 Reset mid-byte SHALL abort the byte with no partial word delivered; EN inputs during reset SHALL be ignored.
REQ-039 Sticky flags SHALL clear only on reset.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-040 Host sends bytes 78,56,34,12 -> RDY_get rises once, get_pin=0x12345678, and RDY_get falls one cycle after the EN_get pop.
REQ-041 Put 0xA5C3F00F with ctsN=0 -> uart_sout carries bytes 0F,F0,C3,A5, each 160 cycles long, and the start bit appears within 2 cycles.
REQ-042 Hold ctsN=1, put 5 words -> RDY_put low after the 4th put, uart_sout stays 1; drop ctsN -> all 4 words are sent in order.
REQ-043 Host sends 5 words with no gets -> rtsN=1 once occupancy reaches 3, the 5th word is dropped, overflow_err=1, and gets return words 1-4.
REQ-044 Byte with stop bit 0, then bytes 01,02,03,04 -> framing_err=1, and get_pin=0x04030201.
REQ-045 Assert reset during the 3rd data bit of a TX byte and after 2 RX bytes -> uart_sout=1 immediately, and the next 4 RX bytes form a fresh word.

Source files
------------

// File: rtl/uart_msg_bridge_if.sv
// Message-side and serial-side signal bundle for uart_msg_bridge.
// The slave modport is the bridge itself; the master modport is whoever
// drives the host line and the 32-bit put/get message ports.
interface uart_msg_bridge_if;
  logic        uart_sin;
  logic        uart_sout;
  logic        uart_ctsN;
  logic        uart_rtsN;
  logic [31:0] ppcMessageInput_put_pin;
  logic        EN_ppcMessageInput_put_pin;
  logic        RDY_ppcMessageInput_put_pin;
  logic [31:0] ppcMessageOutput_get_pin;
  logic        EN_ppcMessageOutput_get_pin;
  logic        RDY_ppcMessageOutput_get_pin;
  logic        framing_err;
  logic        overflow_err;

  modport slave (
    input  uart_sin, uart_ctsN,
    input  ppcMessageInput_put_pin, EN_ppcMessageInput_put_pin,
    input  EN_ppcMessageOutput_get_pin,
    output uart_sout, uart_rtsN,
    output RDY_ppcMessageInput_put_pin,
    output ppcMessageOutput_get_pin, RDY_ppcMessageOutput_get_pin,
    output framing_err, overflow_err
  );

  modport master (
    output uart_sin, uart_ctsN,
    output ppcMessageInput_put_pin, EN_ppcMessageInput_put_pin,
    output EN_ppcMessageOutput_get_pin,
    input  uart_sout, uart_rtsN,
    input  RDY_ppcMessageInput_put_pin,
    input  ppcMessageOutput_get_pin, RDY_ppcMessageOutput_get_pin,
    input  framing_err, overflow_err
  );
endinterface

// File: rtl/uart_msg_bridge.sv
// Purpose: bridges 32-bit put/get message ports to an 8N1 UART, little-endian bytes.
// Latency: RX word visible the cycle after its 4th stop-bit sample; TX start bit 1 cycle after a put.
// Backpressure: RDY_put drops when the TX FIFO is full; rtsN asserts near RX-full; ctsN gates TX per byte.

// Small synchronous FIFO: show-ahead head, simultaneous push/pop always legal.
module uart_msg_bridge_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             pop_ok, push_ok;

  // A pop frees the slot the same cycle, so a full FIFO still takes a push alongside a pop
  assign pop_ok     = pop_i && (count_q != '0);
  assign push_ok    = push_i && ((count_q != FULL_CNT) || pop_ok);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Storage needs no reset: contents are only ever read behind a valid count
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module uart_msg_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              sys_clk_pin,
  input  logic              sys_rst_pin,
  uart_msg_bridge_if.slave  bus
);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] RTS_LEVEL = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------- input synchronizers ----------------
  logic sin_meta_q, sin_sync_q, sin_prev_q;
  logic cts_meta_q, cts_sync_q;

  // Two-flop synchronizers, plus one extra stage on sin for falling-edge detect
  always_ff @(posedge sys_clk_pin or posedge sys_rst_pin) begin
    if (sys_rst_pin) begin
      sin_meta_q <= 1'b1;
      sin_sync_q <= 1'b1;
      sin_prev_q <= 1'b1;
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      sin_meta_q <= bus.uart_sin;
      sin_sync_q <= sin_meta_q;
      sin_prev_q <= sin_sync_q;
      cts_meta_q <= bus.uart_ctsN;
      cts_sync_q <= cts_meta_q;
    end
  end

  // ---------------- RX path ----------------
  rx_state_t     rx_state_q;
  logic [15:0]   rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic [1:0]    rx_idx_q;
  logic [23:0]   rx_pack_q;
  logic          framing_err_q, overflow_err_q;
  logic          rx_stop_sample, rx_push, rx_pop, rx_full, rx_empty, rx_drop;
  logic [31:0]   rx_word, rx_head;
  logic [CW-1:0] rx_count;

  assign rx_stop_sample = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST);
  // The 4th byte goes straight from the shifter into the FIFO alongside the packed three
  assign rx_push  = rx_stop_sample && sin_sync_q && (rx_idx_q == 2'd3);
  assign rx_word  = {rx_shift_q, rx_pack_q};
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_pop   = bus.EN_ppcMessageOutput_get_pin && !rx_empty;
  assign rx_drop  = rx_push && rx_full && !rx_pop;

  // RX bit-level FSM, byte packer and sticky error flags
  always_ff @(posedge sys_clk_pin or posedge sys_rst_pin) begin
    if (sys_rst_pin) begin
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_idx_q       <= '0;
      rx_pack_q      <= '0;
      framing_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          if (sin_prev_q && !sin_sync_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            // A line already back high at mid-start was a glitch, not a frame
            rx_state_q <= sin_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {sin_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (sin_sync_q) begin
              case (rx_idx_q)
                2'd0:    rx_pack_q[7:0]   <= rx_shift_q;
                2'd1:    rx_pack_q[15:8]  <= rx_shift_q;
                2'd2:    rx_pack_q[23:16] <= rx_shift_q;
                default: ;
              endcase
              rx_idx_q <= rx_idx_q + 2'd1;
            end else begin
              // Bad stop bit: drop the byte and leave the packer where it was
              framing_err_q <= 1'b1;
            end
            if (rx_drop) overflow_err_q <= 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  uart_msg_bridge_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i      (sys_clk_pin),
    .rst_i      (sys_rst_pin),
    .push_i     (rx_push),
    .push_dat_i (rx_word),
    .pop_i      (rx_pop),
    .head_dat_o (rx_head),
    .count_o    (rx_count)
  );

  assign bus.RDY_ppcMessageOutput_get_pin = !rx_empty;
  assign bus.ppcMessageOutput_get_pin     = rx_empty ? 32'd0 : rx_head;
  // Ask the host to pause one word early so a word already in flight still fits
  assign bus.uart_rtsN                    = (rx_count >= RTS_LEVEL);
  assign bus.framing_err                  = framing_err_q;
  assign bus.overflow_err                 = overflow_err_q;

  // ---------------- TX path ----------------
  tx_state_t     tx_state_q;
  logic [15:0]   tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic [1:0]    tx_idx_q;
  logic [31:0]   tx_hold_q;
  logic          sout_q;
  logic          tx_bit_end, tx_have, tx_launch, tx_pop, tx_push, tx_full, tx_empty;
  logic [7:0]    tx_next_byte;
  logic [31:0]   tx_head;
  logic [CW-1:0] tx_count;

  assign tx_empty   = (tx_count == '0);
  assign tx_full    = (tx_count == FULL_CNT);
  assign tx_push    = bus.EN_ppcMessageInput_put_pin && !tx_full;
  assign tx_bit_end = (tx_cnt_q == BIT_LAST);
  // A nonzero byte index means a word is part-way out and bytes 1..3 are pending
  assign tx_have    = (tx_idx_q != 2'd0) || !tx_empty;
  // Launch from idle, or straight out of a finished stop bit so bytes run back to back
  assign tx_launch  = tx_have && !cts_sync_q &&
                      ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_bit_end));
  assign tx_pop     = tx_launch && (tx_idx_q == 2'd0);

  // Byte 0 comes from the FIFO head as it is popped; the rest from the holding register
  always_comb begin
    tx_next_byte = tx_head[7:0];
    case (tx_idx_q)
      2'd1:    tx_next_byte = tx_hold_q[15:8];
      2'd2:    tx_next_byte = tx_hold_q[23:16];
      2'd3:    tx_next_byte = tx_hold_q[31:24];
      default: tx_next_byte = tx_head[7:0];
    endcase
  end

  // TX bit-level FSM with a registered serial output
  always_ff @(posedge sys_clk_pin or posedge sys_rst_pin) begin
    if (sys_rst_pin) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_idx_q   <= '0;
      tx_hold_q  <= '0;
      sout_q     <= 1'b1;
    end else if (tx_launch) begin
      tx_state_q <= TX_START;
      tx_cnt_q   <= '0;
      sout_q     <= 1'b0;
      tx_shift_q <= tx_next_byte;
      tx_idx_q   <= tx_idx_q + 2'd1;
      if (tx_idx_q == 2'd0) tx_hold_q <= tx_head;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_cnt_q <= '0;
          sout_q   <= 1'b1;
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            sout_q     <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              sout_q     <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              sout_q     <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  uart_msg_bridge_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i      (sys_clk_pin),
    .rst_i      (sys_rst_pin),
    .push_i     (tx_push),
    .push_dat_i (bus.ppcMessageInput_put_pin),
    .pop_i      (tx_pop),
    .head_dat_o (tx_head),
    .count_o    (tx_count)
  );

  assign bus.RDY_ppcMessageInput_put_pin = !tx_full;
  assign bus.uart_sout                   = sout_q;
endmodule

// File: tb/tb_uart_msg_bridge.sv
// Bench for uart_msg_bridge at 16 clocks/bit and 4-word FIFOs.
// Host-side serial driver and decoder plus queue-based expectations.
module tb_uart_msg_bridge;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rdy_rises = 0;
  logic rdy_prev  = 1'b0;

  uart_msg_bridge_if bus();

  uart_msg_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk_pin (clk),
    .sys_rst_pin (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.RDY_ppcMessageOutput_get_pin === 1'b1 && rdy_prev === 1'b0) rdy_rises++;
    rdy_prev = bus.RDY_ppcMessageOutput_get_pin;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // ---------------- stimulus / observation helpers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.uart_sin = frame[i];
      repeat (CPB) @(negedge clk);
    end
    bus.uart_sin = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)), 1'b1);
  endtask

  task automatic put_word(input logic [31:0] w, output logic acc, output int at_cyc);
    @(negedge clk);
    acc    = bus.RDY_ppcMessageInput_put_pin;
    at_cyc = cyc;
    bus.ppcMessageInput_put_pin    = w;
    bus.EN_ppcMessageInput_put_pin = 1'b1;
    @(negedge clk);
    bus.EN_ppcMessageInput_put_pin = 1'b0;
  endtask

  task automatic get_word(output logic rdy, output logic [31:0] d);
    @(negedge clk);
    rdy = bus.RDY_ppcMessageOutput_get_pin;
    d   = bus.ppcMessageOutput_get_pin;
    bus.EN_ppcMessageOutput_get_pin = 1'b1;
    @(negedge clk);
    bus.EN_ppcMessageOutput_get_pin = 1'b0;
  endtask

  // Decodes one frame from uart_sout; every bit slot must hold steady for CPB samples
  task automatic tx_recv(input int limit, output logic [7:0] b, output int start_cyc, output logic ok);
    int n;
    logic [9:0] v;
    ok = 1'b1; n = 0; b = 8'h00; start_cyc = -1; v = '0;
    do begin @(negedge clk); n++; end while (bus.uart_sout !== 1'b0 && n < limit);
    if (bus.uart_sout !== 1'b0) begin ok = 1'b0; return; end
    start_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      for (int s = 0; s < CPB; s++) begin
        if (!(k == 0 && s == 0)) @(negedge clk);
        if (s == 0) v[k] = bus.uart_sout;
        else if (bus.uart_sout !== v[k]) ok = 1'b0;
      end
    end
    if (v[0] !== 1'b0 || v[9] !== 1'b1) ok = 1'b0;
    b = v[8:1];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 1) begin rst = 1'b0; @(negedge clk); end
      total++; if (bus.uart_sout !== 1'b1) begin bad++; $display("FAIL reset_sout ph%0d: got %b want 1", ph, bus.uart_sout); end
      total++; if (bus.uart_rtsN !== 1'b0) begin bad++; $display("FAIL reset_rtsN ph%0d: got %b want 0", ph, bus.uart_rtsN); end
      total++; if (bus.RDY_ppcMessageInput_put_pin !== 1'b1) begin bad++; $display("FAIL reset_rdy_put ph%0d: got %b want 1", ph, bus.RDY_ppcMessageInput_put_pin); end
      total++; if (bus.RDY_ppcMessageOutput_get_pin !== 1'b0) begin bad++; $display("FAIL reset_rdy_get ph%0d: got %b want 0", ph, bus.RDY_ppcMessageOutput_get_pin); end
      total++; if (bus.ppcMessageOutput_get_pin !== 32'd0) begin bad++; $display("FAIL reset_get_pin ph%0d: got %h want 0", ph, bus.ppcMessageOutput_get_pin); end
      total++; if (bus.framing_err !== 1'b0) begin bad++; $display("FAIL reset_framing ph%0d: got %b want 0", ph, bus.framing_err); end
      total++; if (bus.overflow_err !== 1'b0) begin bad++; $display("FAIL reset_overflow ph%0d: got %b want 0", ph, bus.overflow_err); end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rx_word();
    int r0;
    logic rdy;
    logic [31:0] d;
    r0 = rdy_rises;
    send_word(32'h12345678);
    @(negedge clk);
    total++; if (bus.RDY_ppcMessageOutput_get_pin !== 1'b1) begin bad++; $display("FAIL rx_word_rdy: got %b want 1", bus.RDY_ppcMessageOutput_get_pin); end
    total++; if (bus.ppcMessageOutput_get_pin !== 32'h12345678) begin bad++; $display("FAIL rx_word_data: got %h want 12345678", bus.ppcMessageOutput_get_pin); end
    total++; if (rdy_rises !== r0 + 1) begin bad++; $display("FAIL rx_word_rises: got %0d want %0d", rdy_rises, r0 + 1); end
    get_word(rdy, d);
    total++; if (bus.RDY_ppcMessageOutput_get_pin !== 1'b0) begin bad++; $display("FAIL rx_word_rdy_after_pop: got %b want 0", bus.RDY_ppcMessageOutput_get_pin); end
    total++; if (bus.ppcMessageOutput_get_pin !== 32'd0) begin bad++; $display("FAIL rx_word_empty_data: got %h want 0", bus.ppcMessageOutput_get_pin); end
  endtask

  task automatic test_tx_word();
    logic [31:0] w;
    logic acc, ok;
    logic [7:0] b, eb;
    int c0, sc, prev;
    w = 32'hA5C3F00F;
    put_word(w, acc, c0);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL tx_word_accept: got %b want 1", acc); end
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      eb = 8'(w >> (8 * i));
      tx_recv(400, b, sc, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL tx_word_frame%0d: got ok=%b want 1", i, ok); end
      total++; if (b !== eb) begin bad++; $display("FAIL tx_word_byte%0d: got %h want %h", i, b, eb); end
      if (i == 0) begin
        total++; if (sc - c0 > 3 || sc < 0) begin bad++; $display("FAIL tx_start_latency: got %0d want <=3 negedges", sc - c0); end
      end else begin
        total++; if (sc - prev !== 10 * CPB) begin bad++; $display("FAIL tx_word_spacing%0d: got %0d want %0d", i, sc - prev, 10 * CPB); end
      end
      prev = sc;
    end
  endtask

  task automatic test_cts_flow();
    logic [31:0] q[$];
    logic [31:0] w;
    logic acc, ok, stay1;
    logic [7:0] b, eb;
    int c, sc, prev;
    bus.uart_ctsN = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      put_word(w, acc, c);
      q.push_back(w);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL cts_put%0d_accept: got %b want 1", i, acc); end
    end
    total++; if (bus.RDY_ppcMessageInput_put_pin !== 1'b0) begin bad++; $display("FAIL cts_rdy_put_full: got %b want 0", bus.RDY_ppcMessageInput_put_pin); end
    put_word(32'hDEADBEEF, acc, c);
    total++; if (acc !== 1'b0) begin bad++; $display("FAIL cts_put5_refused: got %b want 0", acc); end
    stay1 = 1'b1;
    repeat (100) begin @(negedge clk); if (bus.uart_sout !== 1'b1) stay1 = 1'b0; end
    total++; if (stay1 !== 1'b1) begin bad++; $display("FAIL cts_hold_idle: got %b want 1", stay1); end
    bus.uart_ctsN = 1'b0;
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      eb = 8'(q[i / 4] >> (8 * (i % 4)));
      tx_recv(400, b, sc, ok);
      total++; if (ok !== 1'b1 || b !== eb) begin bad++; $display("FAIL cts_byte%0d: got %h ok=%b want %h", i, b, ok, eb); end
      if (i > 0) begin
        total++; if (sc - prev !== 10 * CPB) begin bad++; $display("FAIL cts_spacing%0d: got %0d want %0d", i, sc - prev, 10 * CPB); end
      end
      prev = sc;
    end
    tx_recv(400, b, sc, ok);
    total++; if (sc !== -1) begin bad++; $display("FAIL cts_no_fifth_word: got start at %0d want none", sc); end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] w[5];
    logic [31:0] d;
    logic rdy, exp_rts;
    for (int i = 0; i < 5; i++) begin
      w[i] = $urandom;
      send_word(w[i]);
      @(negedge clk);
      exp_rts = ((i + 1) >= DEPTH - 1);
      total++; if (bus.uart_rtsN !== exp_rts) begin bad++; $display("FAIL ovf_rts%0d: got %b want %b", i, bus.uart_rtsN, exp_rts); end
    end
    total++; if (bus.overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", bus.overflow_err); end
    for (int i = 0; i < 4; i++) begin
      get_word(rdy, d);
      total++; if (rdy !== 1'b1 || d !== w[i]) begin bad++; $display("FAIL ovf_get%0d: got rdy=%b %h want 1 %h", i, rdy, d, w[i]); end
    end
    total++; if (bus.RDY_ppcMessageOutput_get_pin !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %b want 0", bus.RDY_ppcMessageOutput_get_pin); end
    total++; if (bus.uart_rtsN !== 1'b0) begin bad++; $display("FAIL ovf_rts_released: got %b want 0", bus.uart_rtsN); end
  endtask

  task automatic test_framing();
    logic rdy;
    logic [31:0] d;
    total++; if (bus.framing_err !== 1'b0) begin bad++; $display("FAIL frm_before: got %b want 0", bus.framing_err); end
    send_byte(8'($urandom), 1'b0);
    bus.uart_sin = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    total++; if (bus.framing_err !== 1'b1) begin bad++; $display("FAIL frm_flag: got %b want 1", bus.framing_err); end
    total++; if (bus.overflow_err !== 1'b1) begin bad++; $display("FAIL frm_ovf_sticky: got %b want 1", bus.overflow_err); end
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    @(negedge clk);
    total++; if (bus.RDY_ppcMessageOutput_get_pin !== 1'b1 || bus.ppcMessageOutput_get_pin !== 32'h04030201) begin
      bad++; $display("FAIL frm_word: got rdy=%b %h want 1 04030201", bus.RDY_ppcMessageOutput_get_pin, bus.ppcMessageOutput_get_pin); end
    get_word(rdy, d);
  endtask

  task automatic test_reset_midbyte();
    logic acc, stay1, rdy;
    logic [31:0] w, d;
    int c, n;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    put_word(32'h9ABCDE00, acc, c);
    n = 0;
    while (bus.uart_sout !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    total++; if (bus.uart_sout !== 1'b0) begin bad++; $display("FAIL rstmid_tx_started: got %b want 0", bus.uart_sout); end
    repeat (CPB + 2 * CPB + CPB / 2) @(negedge clk);
    total++; if (bus.uart_sout !== 1'b0) begin bad++; $display("FAIL rstmid_bit2: got %b want 0", bus.uart_sout); end
    rst = 1'b1;
    bus.ppcMessageInput_put_pin     = $urandom;
    bus.EN_ppcMessageInput_put_pin  = 1'b1;
    bus.EN_ppcMessageOutput_get_pin = 1'b1;
    #1;
    total++; if (bus.uart_sout !== 1'b1) begin bad++; $display("FAIL rstmid_sout: got %b want 1", bus.uart_sout); end
    total++; if (bus.framing_err !== 1'b0 || bus.overflow_err !== 1'b0) begin bad++; $display("FAIL rstmid_flags: got %b%b want 00", bus.framing_err, bus.overflow_err); end
    repeat (3) @(negedge clk);
    bus.EN_ppcMessageInput_put_pin  = 1'b0;
    bus.EN_ppcMessageOutput_get_pin = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.RDY_ppcMessageOutput_get_pin !== 1'b0 || bus.RDY_ppcMessageInput_put_pin !== 1'b1) begin
      bad++; $display("FAIL rstmid_rdy: got get=%b put=%b want 0 1", bus.RDY_ppcMessageOutput_get_pin, bus.RDY_ppcMessageInput_put_pin); end
    stay1 = 1'b1;
    repeat (200) begin @(negedge clk); if (bus.uart_sout !== 1'b1) stay1 = 1'b0; end
    total++; if (stay1 !== 1'b1) begin bad++; $display("FAIL rstmid_no_tx: got %b want 1", stay1); end
    w = $urandom;
    send_word(w);
    @(negedge clk);
    total++; if (bus.RDY_ppcMessageOutput_get_pin !== 1'b1 || bus.ppcMessageOutput_get_pin !== w) begin
      bad++; $display("FAIL rstmid_fresh_word: got rdy=%b %h want 1 %h", bus.RDY_ppcMessageOutput_get_pin, bus.ppcMessageOutput_get_pin, w); end
    get_word(rdy, d);
  endtask

  task automatic test_concurrent();
    logic [31:0] rxw[3];
    logic [31:0] txw[3];
    logic        acc[3];
    logic [7:0]  rb[12];
    int          sc[12];
    logic        okv[12];
    logic        rdy;
    logic [31:0] d;
    logic [7:0]  eb;
    for (int i = 0; i < 3; i++) begin rxw[i] = $urandom; txw[i] = $urandom; end
    fork
      begin for (int i = 0; i < 3; i++) send_word(rxw[i]); end
      begin for (int j = 0; j < 3; j++) begin int c; put_word(txw[j], acc[j], c); end end
      begin for (int k = 0; k < 12; k++) tx_recv(400, rb[k], sc[k], okv[k]); end
    join
    for (int i = 0; i < 3; i++) begin
      total++; if (acc[i] !== 1'b1) begin bad++; $display("FAIL conc_put%0d: got %b want 1", i, acc[i]); end
    end
    for (int i = 0; i < 12; i++) begin
      eb = 8'(txw[i / 4] >> (8 * (i % 4)));
      total++; if (okv[i] !== 1'b1 || rb[i] !== eb) begin bad++; $display("FAIL conc_tx%0d: got %h ok=%b want %h", i, rb[i], okv[i], eb); end
      if (i > 0) begin
        total++; if (sc[i] - sc[i-1] !== 10 * CPB) begin bad++; $display("FAIL conc_spacing%0d: got %0d want %0d", i, sc[i] - sc[i-1], 10 * CPB); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      get_word(rdy, d);
      total++; if (rdy !== 1'b1 || d !== rxw[i]) begin bad++; $display("FAIL conc_rx%0d: got rdy=%b %h want 1 %h", i, rdy, d, rxw[i]); end
    end
  endtask

  initial begin
    bus.uart_sin                    = 1'b1;
    bus.uart_ctsN                   = 1'b0;
    bus.ppcMessageInput_put_pin     = 32'd0;
    bus.EN_ppcMessageInput_put_pin  = 1'b0;
    bus.EN_ppcMessageOutput_get_pin = 1'b0;
    test_reset();
    test_rx_word();
    test_tx_word();
    test_cts_flow();
    test_rx_overflow();
    test_framing();
    test_reset_midbyte();
    test_concurrent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
